// File: rtl/data_req_ctrl.sv
// rtl/data_req_ctrl.sv - memory-stage data bus request controller
//
// Purpose: turns a memory-stage load/store into one data-bus transaction,
// stalls the pipeline while the access is in flight, holds load data for
// write-back, and drains transactions orphaned by a pipeline flush.
//
// Ports:
//   cpu_clk, cpu_rst_n            clock, asynchronous active-low reset
//   mem_req_i, mem_wr_i           access request, 1 = store
//   mem_size_i                    00 byte, 01 half, 10 word
//   mem_addr_i, mem_wdata_i       virtual address, store data
//   mem_advance_i, flush_i        memory stage advances / is flushed
//   data_req, data_wr, data_size  bus command
//   data_addr, data_wdata         bus command address / write data
//   data_addr_ok, data_data_ok    bus command accepted / data returned
//   data_rdata                    bus read data
//   stallreq_mem                  pipeline freeze request
//   dm_o                          load result for write-back
module data_req_ctrl #(
    parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        mem_req_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_advance_i,
    input  logic        flush_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stallreq_mem,
    output logic [31:0] dm_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dm_q, dm_d;
    // Remembers a flush seen while the command is still waiting for
    // acceptance; the command must stay on the bus until accepted.
    logic        flushed_q, flushed_d;
    logic        kill;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            dm_q      <= 32'h0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dm_q      <= dm_d;
            flushed_q <= flushed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dm_d         = dm_q;
        flushed_d    = 1'b0;
        kill         = flush_i | flushed_q;
        data_req     = 1'b0;
        data_wr      = wr_q;
        data_size    = size_q;
        data_addr    = addr_q;
        data_wdata   = wdata_q;
        stallreq_mem = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Reset gating keeps the combinational command path quiet
                // while cpu_rst_n is low.
                if (mem_req_i && !flush_i && cpu_rst_n) begin
                    data_req     = 1'b1;
                    stallreq_mem = 1'b1;
                    data_wr      = mem_wr_i;
                    data_size    = mem_size_i;
                    data_addr    = mem_addr_i & ADDR_MASK;
                    data_wdata   = mem_wdata_i;
                    wr_d         = mem_wr_i;
                    size_d       = mem_size_i;
                    addr_d       = mem_addr_i & ADDR_MASK;
                    wdata_d      = mem_wdata_i;
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            state_d = S_DONE;
                            if (!mem_wr_i) begin
                                dm_d = data_rdata;
                            end
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                data_req     = 1'b1;
                stallreq_mem = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (kill) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DONE;
                            if (!wr_q) begin
                                dm_d = data_rdata;
                            end
                        end
                    end else begin
                        state_d = kill ? S_DISCARD : S_WAIT;
                    end
                end else begin
                    flushed_d = kill;
                end
            end
            S_WAIT: begin
                stallreq_mem = 1'b1;
                if (flush_i) begin
                    state_d = data_data_ok ? S_IDLE : S_DISCARD;
                end else if (data_data_ok) begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        dm_d = data_rdata;
                    end
                end
            end
            S_DONE: begin
                // No request here: the finished instruction is still in the
                // memory stage and must not issue a second time.
                if (flush_i || mem_advance_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                stallreq_mem = mem_req_i;
                if (data_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dm_o = dm_q;

endmodule
